// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: autonomous APB master for uart_core.
// Configures baud/control, then polls STATUS and moves RX/TX bytes.
module uart_apb_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  BRG_OFS   = 8'h08,
  parameter logic [31:0] BRG_VAL   = 32'h0000_0019,
  parameter logic [7:0]  CTRL_OFS  = 8'h00,
  parameter logic [31:0] CTRL_VAL  = 32'h0000_0001,
  parameter logic [7:0]  STAT_OFS  = 8'h04,
  parameter logic [7:0]  DATA_OFS  = 8'h0C,
  parameter int          RXNE_BIT  = 0,
  parameter int          TXF_BIT   = 1,
  parameter int          POLL_GAP  = 4
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        start,
  output logic        cfg_done,
  output logic        busy,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_BRG, S_CTRL, S_POLL,
    S_RX, S_TX, S_WAIT
  } state_t;

  localparam logic [7:0] LP_GAP_M1 = 8'(POLL_GAP - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_poll_nxt;
  logic        r_acc;
  logic        w_acc_nxt;
  logic        w_xfer;
  logic        w_setup_nxt;
  logic        w_gap_end;
  logic [7:0]  w_ofs;
  logic        w_wr;
  logic [31:0] w_wdata;

  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_cfg_done;
  logic        r_busy;
  logic [7:0]  r_cnt;

  logic        w_unused_prdata;
  assign w_unused_prdata = ^prdata[31:8];

  assign w_gap_end = (r_cnt == LP_GAP_M1);

  assign w_poll_nxt =
    prdata[RXNE_BIT]                  ? S_RX :
    (tx_valid && !prdata[TXF_BIT])    ? S_TX :
                                        S_WAIT;

  // state register: FSM state plus APB phase (0=SETUP, 1=ACCESS)
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // next state: every APB state runs SETUP then ACCESS
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_BRG;
      S_WAIT: if (w_gap_end) w_state_nxt = S_POLL;
      default: begin
        w_acc_nxt = ~r_acc;
        if (r_acc) begin
          if (r_state == S_BRG)
            w_state_nxt = S_CTRL;
          else if (r_state == S_POLL)
            w_state_nxt = w_poll_nxt;
          else
            w_state_nxt = S_POLL;
        end
      end
    endcase
  end

  // outputs decoded from the current state and phase
  always_comb begin
    w_xfer   = (r_state != S_IDLE) && (r_state != S_WAIT);
    psel     = w_xfer;
    penable  = w_xfer & r_acc;
    tx_ready = (r_state == S_TX) & ~r_acc;
  end

  // address/data for the transfer about to enter SETUP
  always_comb begin
    w_setup_nxt = (w_state_nxt != S_IDLE) &&
                  (w_state_nxt != S_WAIT) && !w_acc_nxt;
    w_ofs   = STAT_OFS;
    w_wr    = 1'b0;
    w_wdata = CTRL_VAL;
    unique case (w_state_nxt)
      S_BRG: begin
        w_ofs = BRG_OFS; w_wr = 1'b1; w_wdata = BRG_VAL;
      end
      S_CTRL: begin
        w_ofs = CTRL_OFS; w_wr = 1'b1; w_wdata = CTRL_VAL;
      end
      S_RX: w_ofs = DATA_OFS;
      S_TX: begin
        w_ofs = DATA_OFS; w_wr = 1'b1;
        w_wdata = {24'h0, tx_data};
      end
      default: w_ofs = STAT_OFS;
    endcase
  end

  // datapath: APB bus regs, RX capture, status flags, poll gap
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_cfg_done <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_setup_nxt) begin
        r_paddr  <= BASE_ADDR + {24'h0, w_ofs};
        r_pwrite <= w_wr;
        if (w_wr) r_pwdata <= w_wdata;
      end
      r_rx_valid <= (r_state == S_RX) && r_acc;
      if ((r_state == S_RX) && r_acc)
        r_rx_data <= prdata[7:0];
      if ((r_state == S_CTRL) && r_acc)
        r_cfg_done <= 1'b1;
      if ((r_state == S_IDLE) && start)
        r_busy <= 1'b1;
      if (r_state == S_WAIT)
        r_cnt <= w_gap_end ? 8'd0 : r_cnt + 8'd1;
    end
  end

  assign paddr    = r_paddr;
  assign pwrite   = r_pwrite;
  assign pwdata   = r_pwdata;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign cfg_done = r_cfg_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: scoreboard bench with an APB uart model.
// Expected APB/RX traffic is queued by stimulus, popped by the monitor.
module tb_uart_apb_sequencer;

  localparam logic [31:0] A_BRG  = 32'h08;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_STAT = 32'h04;
  localparam logic [31:0] A_DATA = 32'h0C;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        cfg_done, busy, tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite;

  uart_apb_sequencer dut (
    .pclk(pclk), .prst_n(prst_n), .start(start),
    .cfg_done(cfg_done), .busy(busy),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } apb_t;

  apb_t       expq[$];
  logic [7:0] rxq[$];
  apb_t       e;
  logic [7:0] er;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_stat = 0, tx_cnt = 0;
  int last_stat_cyc = 0, last_gap = 0;
  int rx_pushed = 0, rx_popped = 0;
  int t0, n0;
  logic       tb_txf = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // uart_core slave model: STATUS from model flags, DATA = rx byte
  always_comb begin
    prdata = 32'hDEAD_BEEF;
    if (paddr == A_DATA) prdata = {24'h0, rx_byte};
    else if (paddr == A_STAT)
      prdata = {30'h0, tb_txf, (rx_pushed != rx_popped)};
  end

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (prst_n && psel && penable && !pwrite && paddr == A_DATA)
      rx_popped <= rx_popped + 1;
  end

  // monitor: latency, poll spacing, APB and RX scoreboards
  always @(negedge pclk) begin
    if (prst_n) begin
      if (tx_ready) tx_cnt++;
      if (psel && !penable) begin
        if (paddr == A_STAT) begin
          last_gap = cyc - last_stat_cyc;
          last_stat_cyc = cyc;
        end else if (paddr == A_DATA)
          chk("data_lat", 72'(cyc - last_stat_cyc), 72'd2);
      end
      if (psel && penable && paddr == A_STAT) n_stat++;
      else if (psel && penable) begin
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL unexp_apb: got w=%0b a=%h d=%h want none",
                   pwrite, paddr, pwdata);
        end else begin
          e = expq.pop_front();
          chk("apb_xfer",
              {7'h0, pwrite, paddr, pwrite ? pwdata : 32'h0},
              {7'h0, e});
        end
      end
      if (rx_valid) begin
        if (rxq.size() == 0) begin
          n_chk++;
          $display("FAIL unexp_rx: got %h want none", rx_data);
        end else begin
          er = rxq.pop_front();
          chk("rx_data", 72'(rx_data), 72'(er));
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_txr(string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge pclk);
      ok = tx_ready;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: got no tx_ready want pulse", nm);
    end
  endtask

  task automatic wait_rx(string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge pclk);
      ok = rx_valid;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: got no rx_valid want pulse", nm);
    end
  endtask

  // {psel,penable,pwrite,cfg_done,busy,paddr,pwdata} per config cycle
  function automatic logic [71:0] cfg_exp(int c);
    case (c)
      1:       return {3'b0, 5'b10101, A_BRG,  32'h19};
      2:       return {3'b0, 5'b11101, A_BRG,  32'h19};
      3:       return {3'b0, 5'b10101, A_CTRL, 32'h01};
      4:       return {3'b0, 5'b11101, A_CTRL, 32'h01};
      default: return {3'b0, 5'b10011, A_STAT, 32'h01};
    endcase
  endfunction

  task automatic do_config(string nm);
    expq.push_back('{1'b1, A_BRG, 32'h19});
    expq.push_back('{1'b1, A_CTRL, 32'h01});
    start = 1'b1;
    @(negedge pclk);
    chk($sformatf("%s_c0", nm), 72'({psel, busy}), 72'd0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge pclk);
      chk($sformatf("%s_c%0d", nm, c),
          {3'b0, psel, penable, pwrite, cfg_done, busy,
           paddr, pwdata},
          cfg_exp(c));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge pclk);
    #2;
    chk("rst_ctrl",
        72'({psel, penable, pwrite, tx_ready, rx_valid,
             cfg_done, busy, rx_data}), 72'd0);
    chk("rst_bus", 72'({paddr, pwdata}), 72'd0);
    prst_n = 1'b1;
    tick();

    // 1: configuration
    do_config("cfg1");

    // 2: simple TX
    t0 = tx_cnt;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    expq.push_back('{1'b1, A_DATA, 32'hA5});
    wait_txr("tx_a5");
    n0 = n_stat;
    tick();
    tx_valid = 1'b0;
    repeat (5) @(negedge pclk);
    chk("tx_repoll", 72'(n_stat - n0), 72'd1);
    chk("tx_once", 72'(tx_cnt - t0), 72'd1);
    tick();

    // 3: TX FIFO full
    tb_txf = 1'b1;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    t0 = tx_cnt;
    n0 = n_stat;
    for (int i = 0; i < 200 && n_stat < n0 + 3; i++)
      @(negedge pclk);
    chk("full_polls", 72'(n_stat - n0 >= 3), 72'd1);
    chk("full_gap", 72'(last_gap), 72'd6);
    chk("full_no_tx", 72'(tx_cnt - t0), 72'd0);
    expq.push_back('{1'b1, A_DATA, 32'h3C});
    tick();
    tb_txf = 1'b0;
    wait_txr("tx_3c");
    tick();
    tx_valid = 1'b0;
    chk("full_tx_once", 72'(tx_cnt - t0), 72'd1);

    // 4a: status 0x3, RX drained while TX blocked
    tb_txf = 1'b1;
    rx_byte = 8'h5C;
    rx_pushed++;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    t0 = tx_cnt;
    expq.push_back('{1'b0, A_DATA, 32'h0});
    expq.push_back('{1'b1, A_DATA, 32'h77});
    rxq.push_back(8'h5C);
    wait_rx("rx_5c");
    tick();
    chk("rx3_no_tx", 72'(tx_cnt - t0), 72'd0);
    tb_txf = 1'b0;
    wait_txr("tx_77");
    tick();
    tx_valid = 1'b0;

    // 4b: status 0x1 with TX possible, RX must win
    rx_byte = 8'hE1;
    rx_pushed++;
    tx_data = 8'h42;
    tx_valid = 1'b1;
    expq.push_back('{1'b0, A_DATA, 32'h0});
    expq.push_back('{1'b1, A_DATA, 32'h42});
    rxq.push_back(8'hE1);
    wait_rx("rx_e1");
    wait_txr("tx_42");
    tick();
    tx_valid = 1'b0;

    // 5: reset during ACCESS of a TX write
    tx_data = 8'h11;
    tx_valid = 1'b1;
    wait_txr("tx_11");
    tick();
    chk("pre_rst_acc", 72'({psel, penable}), 72'd3);
    prst_n = 1'b0;
    #1;
    chk("mid_rst",
        72'({psel, penable, tx_ready, cfg_done, busy}), 72'd0);
    tx_valid = 1'b0;
    tick();
    prst_n = 1'b1;
    tick();
    do_config("cfg2");

    // 6: start while busy is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) @(negedge pclk);
    chk("busy_hold", 72'({busy, cfg_done}), 72'd3);
    chk("expq_empty", 72'(expq.size()), 72'd0);
    chk("rxq_empty", 72'(rxq.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
